// File: rtl/rv32v_lane_sequencer.sv
// rv32v_lane_sequencer: walks the active elements of one decoded vector
// instruction two lanes per cycle. It drives the per-lane offset, write-enable
// and mask fields of the decode->execute bundle.
//
// Handshake: a group is offered when valid=1. It is consumed on a CLK edge
// where valid=1 and stall=0; stall is the inverse of execute's ready. While it
// is stalled, the offered group holds bit-for-bit. A new instruction is taken
// on a CLK edge where accept=1 (start & idle & ~flush), and accept has no
// dependency on stall.
module rv32v_lane_sequencer #(
  parameter int OFF_W = 5,
  parameter int VL_W  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [VL_W-1:0]       vl_in,
  input  logic [OFF_W-1:0]      vstart_in,
  input  logic                  vm_in,
  input  logic [(1<<OFF_W)-1:0] v0_bits,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  accept,
  output logic                  busy,
  output logic                  valid,
  output logic [OFF_W-1:0]      woffset0,
  output logic [OFF_W-1:0]      woffset1,
  output logic                  wen0,
  output logic                  wen1,
  output logic                  mask0,
  output logic                  mask1,
  output logic                  last,
  output logic                  done,
  output logic                  dbg_state_o
);

  localparam int VLMAX = 1 << OFF_W;
  // The counter is one bit wider than an offset, so cur+1 and cur+2 never alias.
  localparam int CW = OFF_W + 1;
  localparam logic [CW-1:0] VLMAX_C = CW'(VLMAX);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic             last;
    logic             mask1;
    logic             mask0;
    logic             wen1;
    logic             wen0;
    logic [OFF_W-1:0] woff1;
    logic [OFF_W-1:0] woff0;
  } group_t;

  // This function computes the lane fields for the group that starts at element cur.
  function automatic group_t group_at(input logic [CW-1:0]    cur,
                                      input logic [CW-1:0]    vl,
                                      input logic             vm,
                                      input logic [VLMAX-1:0] v0);
    group_t        g;
    logic [CW-1:0] nxt;
    nxt     = cur + CW'(1);
    g.woff0 = cur[OFF_W-1:0];
    g.woff1 = nxt[OFF_W-1:0];
    g.mask0 = vm | v0[cur[OFF_W-1:0]];
    // Lane 1 past the end of the register file has no mask bit.
    g.mask1 = (nxt < VLMAX_C) & (vm | v0[nxt[OFF_W-1:0]]);
    g.wen0  = (cur < vl) & g.mask0;
    g.wen1  = (nxt < vl) & g.mask1;
    g.last  = (cur + CW'(2)) >= vl;
    return g;
  endfunction

  state_e          state_q;
  logic [CW-1:0]   cur_q;
  logic [CW-1:0]   vl_eff_q;
  logic            vm_q;
  logic [VLMAX-1:0] v0_q;
  group_t          grp_q;
  logic            done_q;

  logic [CW-1:0]   vl_eff;
  logic [CW-1:0]   vstart_ext;
  logic [CW-1:0]   cur_d;
  group_t          first_grp;
  group_t          next_grp;

  assign vl_eff     = (vl_in > VL_W'(VLMAX)) ? VLMAX_C : vl_in[CW-1:0];
  assign vstart_ext = {1'b0, vstart_in};
  assign cur_d      = cur_q + CW'(2);
  assign first_grp  = group_at(vstart_ext, vl_eff, vm_in, v0_bits);
  assign next_grp   = group_at(cur_d, vl_eff_q, vm_q, v0_q);

  assign accept      = start & (state_q == S_IDLE) & ~flush;
  assign busy        = (state_q == S_RUN);
  assign valid       = (state_q == S_RUN);
  assign woffset0    = grp_q.woff0;
  assign woffset1    = grp_q.woff1;
  assign wen0        = grp_q.wen0;
  assign wen1        = grp_q.wen1;
  assign mask0       = grp_q.mask0;
  assign mask1       = grp_q.mask1;
  assign last        = grp_q.last;
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // Sequencer FSM: accept, group advance under stall, flush abort, done pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      vl_eff_q <= '0;
      vm_q     <= 1'b0;
      v0_q     <= '0;
      grp_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
        grp_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              vl_eff_q <= vl_eff;
              vm_q     <= vm_in;
              v0_q     <= v0_bits;
              if (vstart_ext < vl_eff) begin
                state_q <= S_RUN;
                cur_q   <= vstart_ext;
                grp_q   <= first_grp;
              end else begin
                // A zero-length instruction still reports completion.
                done_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (!stall) begin
              if (grp_q.last) begin
                state_q <= S_IDLE;
                grp_q   <= '0;
                done_q  <= 1'b1;
              end else begin
                cur_q <= cur_d;
                grp_q <= next_grp;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            grp_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule
